// File: rtl/bf16_mac_pipe_pkg.sv
// Shared bfloat16 types, constants and the rounding/range helper used by
// both the lane multipliers and the accumulate adders.
package bf16_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] man;
    } bf16_t;

    localparam int          BF16_BIAS = 127;
    localparam logic [15:0] BF16_QNAN = 16'h7FC0;
    localparam logic [15:0] BF16_PINF = 16'h7F80;
    localparam logic [15:0] BF16_NINF = 16'hFF80;

    // Per-lane flag vector is {nan, inf, overflow, underflow}
    localparam int FLG_W   = 4;
    localparam int FLG_NAN = 3;
    localparam int FLG_INF = 2;
    localparam int FLG_OVF = 1;
    localparam int FLG_UNF = 0;

    // RNE on a 7-bit fraction plus guard/sticky, then range check.
    // Returns {flags, value}; out-of-range results saturate to signed inf / signed zero.
    function automatic logic [19:0] bf16_round(input logic s, input logic signed [10:0] e,
                                               input logic [6:0] f, input logic g, input logic st);
        logic [7:0]         fr;
        logic signed [10:0] er;
        logic [3:0]         fl;
        logic [15:0]        v;
        fr = {1'b0, f} + {7'd0, g & (st | f[0])};
        er = e + $signed({10'd0, fr[7]});
        fl = '0;
        if (er >= 11'sd255) begin
            v = {s, BF16_PINF[14:0]};
            fl[FLG_OVF] = 1'b1;
            fl[FLG_INF] = 1'b1;
        end else if (er <= 11'sd0) begin
            v = {s, 15'd0};
            fl[FLG_UNF] = 1'b1;
        end else begin
            v = {s, er[7:0], fr[6:0]};
        end
        return {fl, v};
    endfunction

endpackage

// File: rtl/bf16_mac_pipe_if.sv
// Operand and result streams of the MAC engine; master = streamer/writeback side.
interface bf16_mac_pipe_if #(parameter int LANES = 2);
    import bf16_pkg::*;

    logic                        in_valid;
    logic                        in_ready;
    logic                        in_last;
    logic [LANES-1:0][15:0]      in_a;
    logic [LANES-1:0][15:0]      in_b;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES-1:0][15:0]      out_c;
    logic [LANES-1:0][FLG_W-1:0] out_flags;

    modport master (output in_valid, in_last, in_a, in_b, out_ready,
                    input  in_ready, out_valid, out_c, out_flags);
    modport slave  (input  in_valid, in_last, in_a, in_b, out_ready,
                    output in_ready, out_valid, out_c, out_flags);
endinterface

// File: rtl/bf16_add_rne.sv
// Combinational bf16 adder: align, add/subtract, normalise, RNE, flush-to-zero.
module bf16_add_rne
    import bf16_pkg::*;
(
    input  logic [15:0]      i_a,
    input  logic [15:0]      i_b,
    output logic [15:0]      o_sum,
    output logic [FLG_W-1:0] o_flags
);
    bf16_t              w_a, w_b, w_big, w_sml;
    logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_sticky;
    logic [7:0]         w_d;
    logic [17:0]        w_mb, w_ms_full, w_ms;
    logic [18:0]        w_s, w_n;
    logic [4:0]         w_pos;
    logic signed [10:0] w_e;
    logic [19:0]        w_rnd;

    assign w_a = i_a;
    assign w_b = i_b;

    // Significands carry 10 extra low bits so any alignment up to 10 is exact;
    // larger shifts jam the lost bits into bit 0 as sticky.
    always_comb begin
        w_a_nan  = &w_a.exp && |w_a.man;
        w_b_nan  = &w_b.exp && |w_b.man;
        w_a_inf  = &w_a.exp && ~|w_a.man;
        w_b_inf  = &w_b.exp && ~|w_b.man;
        w_a_zero = (w_a.exp == 8'd0);
        w_b_zero = (w_b.exp == 8'd0);
        if ({w_a.exp, w_a.man} >= {w_b.exp, w_b.man}) begin
            w_big = w_a;
            w_sml = w_b;
        end else begin
            w_big = w_b;
            w_sml = w_a;
        end
        w_d       = w_big.exp - w_sml.exp;
        w_mb      = {1'b1, w_big.man, 10'd0};
        w_ms_full = {1'b1, w_sml.man, 10'd0};
        if (w_d >= 8'd18) begin
            w_ms     = '0;
            w_sticky = 1'b1;
        end else begin
            w_ms     = w_ms_full >> w_d;
            w_sticky = |(w_ms_full & ~(18'h3FFFF << w_d));
        end
        w_ms[0] = w_ms[0] | w_sticky;
        w_s = (w_big.sign ^ w_sml.sign) ? ({1'b0, w_mb} - {1'b0, w_ms})
                                        : ({1'b0, w_mb} + {1'b0, w_ms});
        w_pos = '0;
        for (int k = 0; k < 19; k++)
            if (w_s[k]) w_pos = k[4:0];
        w_n   = w_s << (5'd18 - w_pos);
        w_e   = $signed({3'b000, w_big.exp}) + $signed({6'd0, w_pos}) - 11'sd17;
        w_rnd = bf16_round(w_big.sign, w_e, w_n[17:11], w_n[10], |w_n[9:0]);

        o_sum   = w_rnd[15:0];
        o_flags = w_rnd[19:16];
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a.sign != w_b.sign))) begin
            o_sum   = BF16_QNAN;
            o_flags = '0;
            o_flags[FLG_NAN] = 1'b1;
        end else if (w_a_inf || w_b_inf) begin
            o_sum   = w_a_inf ? i_a : i_b;
            o_flags = '0;
            o_flags[FLG_INF] = 1'b1;
        end else if (w_a_zero && w_b_zero) begin
            o_sum   = {w_a.sign & w_b.sign, 15'd0};
            o_flags = '0;
        end else if (w_a_zero) begin
            o_sum   = i_b;
            o_flags = '0;
        end else if (w_b_zero) begin
            o_sum   = i_a;
            o_flags = '0;
        end else if (!w_n[18]) begin
            // exact cancellation
            o_sum   = '0;
            o_flags = '0;
        end
    end
endmodule

// File: rtl/bf16_mac_pipe.sv
// Two-stage multi-lane bf16 MAC: S1 multiplies each lane, S2 accumulates and
// emits all lanes on a registered, back-pressurable result beat at in_last.
module bf16_mac_pipe
    import bf16_pkg::*;
#(
    parameter int LANES = 2,
    parameter bit FTZ   = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    bf16_mac_pipe_if.slave io_bus
);
    logic                        w_adv;
    logic                        r_s1_valid, r_s1_last, r_first, r_out_valid;
    logic [LANES-1:0][15:0]      w_prod, r_prod, w_add, w_sum, r_acc, r_out_c;
    logic [LANES-1:0][FLG_W-1:0] w_mflg, r_pflg, w_aflg, w_flg_nxt, r_acc_flg, r_out_flg;

    // Only flush-to-zero arithmetic is built; FTZ=0 (gradual underflow) is reserved.
    if (FTZ == 1'b0) begin : g_ftz_reserved
    end

    assign w_adv            = !r_out_valid || io_bus.out_ready;
    assign io_bus.in_ready  = w_adv || rst;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_c     = r_out_c;
    assign io_bus.out_flags = r_out_flg;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        bf16_t              w_a, w_b;
        logic               w_nan, w_inf, w_zero, w_sign, w_g, w_st;
        logic [15:0]        w_mp;
        logic [6:0]         w_frac;
        logic signed [10:0] w_e;
        logic [19:0]        w_rnd;

        assign w_a = io_bus.in_a[gi];
        assign w_b = io_bus.in_b[gi];

        // S1 multiply: 8x8 significand product, normalise, RNE, special-value override
        always_comb begin
            w_sign = w_a.sign ^ w_b.sign;
            w_nan  = (&w_a.exp && |w_a.man) || (&w_b.exp && |w_b.man);
            w_inf  = (&w_a.exp && ~|w_a.man) || (&w_b.exp && ~|w_b.man);
            w_zero = (w_a.exp == 8'd0) || (w_b.exp == 8'd0);
            w_mp   = {8'd0, 1'b1, w_a.man} * {8'd0, 1'b1, w_b.man};
            w_e    = $signed({3'b000, w_a.exp}) + $signed({3'b000, w_b.exp})
                   - 11'(BF16_BIAS) + $signed({10'd0, w_mp[15]});
            if (w_mp[15]) begin
                w_frac = w_mp[14:8];
                w_g    = w_mp[7];
                w_st   = |w_mp[6:0];
            end else begin
                w_frac = w_mp[13:7];
                w_g    = w_mp[6];
                w_st   = |w_mp[5:0];
            end
            w_rnd      = bf16_round(w_sign, w_e, w_frac, w_g, w_st);
            w_prod[gi] = w_rnd[15:0];
            w_mflg[gi] = w_rnd[19:16];
            if (w_nan || (w_inf && w_zero)) begin
                w_prod[gi] = BF16_QNAN;
                w_mflg[gi] = '0;
                w_mflg[gi][FLG_NAN] = 1'b1;
            end else if (w_inf) begin
                w_prod[gi] = w_sign ? BF16_NINF : BF16_PINF;
                w_mflg[gi] = '0;
                w_mflg[gi][FLG_INF] = 1'b1;
            end else if (w_zero) begin
                w_prod[gi] = {w_sign, 15'd0};
                w_mflg[gi] = '0;
            end
        end

        bf16_add_rne u_add (
            .i_a     (r_acc[gi]),
            .i_b     (r_prod[gi]),
            .o_sum   (w_add[gi]),
            .o_flags (w_aflg[gi])
        );

        // An empty accumulator acts as the additive identity, so a lone -0 product keeps its sign.
        assign w_sum[gi]     = r_first ? r_prod[gi] : w_add[gi];
        assign w_flg_nxt[gi] = r_acc_flg[gi] | r_pflg[gi] | (r_first ? '0 : w_aflg[gi]);
    end

    // Pipeline advance: S1 capture, S2 accumulate, result load/clear on last
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_first     <= 1'b1;
            r_out_valid <= 1'b0;
            r_prod      <= '0;
            r_pflg      <= '0;
            r_acc       <= '0;
            r_acc_flg   <= '0;
            r_out_c     <= '0;
            r_out_flg   <= '0;
        end else if (w_adv) begin
            r_s1_valid  <= io_bus.in_valid;
            r_s1_last   <= io_bus.in_valid && io_bus.in_last;
            r_prod      <= w_prod;
            r_pflg      <= w_mflg;
            r_out_valid <= r_s1_valid && r_s1_last;
            if (r_s1_valid) begin
                if (r_s1_last) begin
                    r_out_c   <= w_sum;
                    r_out_flg <= w_flg_nxt;
                    r_acc     <= '0;
                    r_acc_flg <= '0;
                    r_first   <= 1'b1;
                end else begin
                    r_acc     <= w_sum;
                    r_acc_flg <= w_flg_nxt;
                    r_first   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_bf16_mac_pipe.sv
// Directed bench for bf16_mac_pipe with two lanes; expected values are hand-computed.
module tb_bf16_mac_pipe;
    import bf16_pkg::*;

    localparam int LANES = 2;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bf16_mac_pipe_if #(.LANES(LANES)) bus ();

    bf16_mac_pipe #(.LANES(LANES), .FTZ(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a0, input logic [15:0] b0,
                         input logic [15:0] a1, input logic [15:0] b1, input logic last);
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        bus.in_a     = {a1, a0};
        bus.in_b     = {b1, b0};
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Last beat; result must appear exactly two cycles after it is presented.
    task automatic one(input string tag, input logic [15:0] a0, input logic [15:0] b0,
                       input logic [15:0] a1, input logic [15:0] b1,
                       input logic [31:0] want_c, input logic [7:0] want_f);
        drive(a0, b0, a1, b1, 1'b1);
        step();
        idle();
        chk({tag, ".early"}, {31'd0, bus.out_valid}, 32'd0);
        step();
        chk({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, ".c"}, 32'(bus.out_c), want_c);
        chk({tag, ".flags"}, 32'(bus.out_flags), {24'd0, want_f});
        step();
    endtask

    initial begin
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_a      = '0;
        bus.in_b      = '0;
        idle();
        step();
        step();
        chk("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst.out_c", 32'(bus.out_c), 32'd0);
        chk("rst.out_flags", 32'(bus.out_flags), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst.in_ready", {31'd0, bus.in_ready}, 32'd1);

        // 1.5*2 = 3, -2*1.5 = -3
        one("mul_basic", 16'h3FC0, 16'h4000, 16'hC000, 16'h3FC0, 32'hC040_4040, 8'h00);
        // product ties: odd LSB rounds up, even LSB stays
        one("rne_mul", 16'h3F81, 16'h3FC0, 16'h3F83, 16'h3FC0, 32'h3FC4_3FC2, 8'h00);

        // streamed dot products: lane0 1+1+3=5, lane1 4+4+4=12; then 4 and 1 with no bubble
        drive(16'h3F80, 16'h3F80, 16'h4000, 16'h4000, 1'b0);
        step();
        drive(16'h3F00, 16'h4000, 16'h4000, 16'h4000, 1'b0);
        step();
        chk("stream.nolast1", {31'd0, bus.out_valid}, 32'd0);
        drive(16'h3FC0, 16'h4000, 16'h4000, 16'h4000, 1'b1);
        step();
        chk("stream.nolast2", {31'd0, bus.out_valid}, 32'd0);
        drive(16'h4000, 16'h4000, 16'h3F80, 16'h3F80, 1'b1);
        step();
        idle();
        chk("stream.dp1.valid", {31'd0, bus.out_valid}, 32'd1);
        chk("stream.dp1.c", 32'(bus.out_c), 32'h4140_40A0);
        step();
        chk("stream.dp2.valid", {31'd0, bus.out_valid}, 32'd1);
        chk("stream.dp2.c", 32'(bus.out_c), 32'h3F80_4080);
        chk("stream.dp2.flags", 32'(bus.out_flags), 32'd0);
        step();
        chk("stream.drain", {31'd0, bus.out_valid}, 32'd0);

        // adder ties: 1 + 2^-8 stays 1.0; 1.0078125 + 2^-8 rounds up
        drive(16'h3F80, 16'h3F80, 16'h3F81, 16'h3F80, 1'b0);
        step();
        one("rne_add", 16'h3B80, 16'h3F80, 16'h3B80, 16'h3F80, 32'h3F82_3F80, 8'h00);

        // zero handling
        one("ftz_in", 16'h0020, 16'h3F80, 16'h0000, 16'h0000, 32'h0000_0000, 8'h00);
        one("neg_zero", 16'h8000, 16'h0000, 16'h0000, 16'h8000, 32'h8000_8000, 8'h00);
        drive(16'h3F80, 16'h0000, 16'h3F80, 16'h3F80, 1'b0);
        step();
        one("cancel", 16'hBF80, 16'h0000, 16'hBF80, 16'h3F80, 32'h0000_0000, 8'h00);

        // special values
        one("inf_x_zero", 16'h7F80, 16'h0000, 16'h0000, 16'h0000, 32'h0000_7FC0, 8'h08);
        one("ovf_unf", 16'h7F00, 16'h4000, 16'h0080, 16'h0080, 32'h0000_7F80, 8'h16);
        one("clean", 16'h3F80, 16'h3F80, 16'h3F80, 16'h4000, 32'h4000_3F80, 8'h00);
        drive(16'h7F80, 16'h0000, 16'h3F80, 16'h3F80, 1'b0);
        step();
        one("sticky_nan", 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 32'h4000_7FC0, 8'h08);
        drive(16'h7F80, 16'h3F80, 16'h0000, 16'h0000, 1'b0);
        step();
        one("inf_minus_inf", 16'hFF80, 16'h3F80, 16'h0000, 16'h0000, 32'h0000_7FC0, 8'h0C);

        // back-pressure: results A=2, B=3 pending, C=4 waiting at the input
        bus.out_ready = 1'b0;
        drive(16'h3F80, 16'h4000, 16'h0000, 16'h0000, 1'b1);
        step();
        drive(16'h4040, 16'h3F80, 16'h0000, 16'h0000, 1'b1);
        step();
        drive(16'h4000, 16'h4000, 16'h0000, 16'h0000, 1'b1);
        chk("bp.valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp.in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("bp.c_a", 32'(bus.out_c), 32'h0000_4000);
        step();
        step();
        chk("bp.hold.valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp.hold.c", 32'(bus.out_c), 32'h0000_4000);
        chk("bp.hold.in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp.release.in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        idle();
        chk("bp.b.valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp.b.c", 32'(bus.out_c), 32'h0000_4040);
        step();
        chk("bp.c.valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp.c.c", 32'(bus.out_c), 32'h0000_4080);
        step();
        chk("bp.drain", {31'd0, bus.out_valid}, 32'd0);

        // reset in the middle of a dot product discards it
        drive(16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 1'b0);
        step();
        step();
        idle();
        rst = 1'b1;
        #1;
        chk("midrst.in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        rst = 1'b0;
        chk("midrst.valid0", {31'd0, bus.out_valid}, 32'd0);
        step();
        step();
        chk("midrst.valid1", {31'd0, bus.out_valid}, 32'd0);
        one("after_rst", 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 32'h3F80_3F80, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
